// File: rtl/imm_decode_stage_pkg.sv
// Shared immediate-format encodings and the XLEN-agnostic decode helper for imm_decode_stage.
package imm_decode_stage_pkg;

  typedef enum logic [2:0] {
    SRC_I   = 3'b000,
    SRC_S   = 3'b001,
    SRC_U   = 3'b010,
    SRC_Z   = 3'b011,
    SRC_SH  = 3'b100,
    SRC_B   = 3'b101,
    SRC_J   = 3'b110,
    SRC_RSV = 3'b111
  } imm_src_e;

  typedef struct packed {
    logic        illegal;
    logic [63:0] imm;
  } dec_t;

  // Decodes at 64 bits; narrower XLEN callers truncate, which keeps sign extension exact.
  function automatic dec_t decode_imm(input logic [24:0] instr, input logic [2:0] src, input int xlen);
    dec_t d;
    logic s;
    d = '0;
    s = instr[24];
    case (imm_src_e'(src))
      SRC_I:   d.imm = {{52{s}}, instr[24:13]};
      SRC_S:   d.imm = {{52{s}}, instr[24:18], instr[4:0]};
      SRC_U:   d.imm = {{32{s}}, instr[24:5], 12'b0};
      SRC_Z:   d.imm = {59'b0, instr[12:8]};
      SRC_SH: begin
        d.imm     = {58'b0, instr[18:13]};
        d.illegal = (xlen == 32) && instr[18];
      end
      SRC_B:   d.imm = {{51{s}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
      SRC_J:   d.imm = {{43{s}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
      default: begin
        d.imm     = 64'd0;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_decode_stage_fifo.sv
// imm_fifo: DEPTH-entry synchronous FIFO with flush; head is zero while empty.
module imm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_pop_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_push_ready = (r_count < FULL);
  assign o_pop_valid  = (r_count != '0);
  assign o_pop_data   = o_pop_valid ? r_mem[r_rd_ptr] : '0;
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = o_pop_valid && i_pop_ready;

  // Storage, pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decodes RISC-V immediates at push and buffers {imm, tag, illegal}.
// Define IMM_DECODE_STATS_EN to add stat_pops/stat_illegal saturating counters.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
`ifdef IMM_DECODE_STATS_EN
  ,
  output logic [31:0]      stat_pops,
  output logic [15:0]      stat_illegal
`endif
);

  localparam int WIDTH = XLEN + TAG_W + 1;

  dec_t             w_dec;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rdata;

  assign w_dec   = decode_imm(in_instr, in_imm_src, XLEN);
  assign w_wdata = {w_dec.imm[XLEN-1:0], in_tag, w_dec.illegal};

  imm_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (flush),
    .i_push_valid (in_valid),
    .o_push_ready (in_ready),
    .i_push_data  (w_wdata),
    .o_pop_valid  (out_valid),
    .i_pop_ready  (out_ready),
    .o_pop_data   (w_rdata)
  );

  assign {out_imm, out_tag, out_illegal} = w_rdata;

`ifdef IMM_DECODE_STATS_EN
  logic [31:0] r_stat_pops;
  logic [15:0] r_stat_illegal;
  logic        w_pop;

  // A flush-cycle handshake is not a pop, since flush wins over pop.
  assign w_pop = out_valid && out_ready && !flush;

  // Saturating pop counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_pops    <= 32'd0;
      r_stat_illegal <= 16'd0;
    end else if (w_pop) begin
      if (r_stat_pops != 32'hFFFF_FFFF) r_stat_pops <= r_stat_pops + 32'd1;
      if (out_illegal && (r_stat_illegal != 16'hFFFF)) r_stat_illegal <= r_stat_illegal + 16'd1;
    end
  end

  assign stat_pops    = r_stat_pops;
  assign stat_illegal = r_stat_illegal;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed scoreboard bench driving an XLEN=32 and an XLEN=64 instance with shared stimulus.
module tb_imm_decode_stage;

  localparam int TAG_W = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, flush, in_valid, out_ready;
  logic [24:0]      in_instr;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;

  logic             rdy32, val32, ill32, rdy64, val64, ill64;
  logic [31:0]      imm32;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag32, tag64;
`ifdef IMM_DECODE_STATS_EN
  logic [31:0] sp32, sp64;
  logic [15:0] si32, si64;
`endif

  imm_decode_stage #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(val32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32)
`ifdef IMM_DECODE_STATS_EN
    , .stat_pops(sp32), .stat_illegal(si32)
`endif
  );

  imm_decode_stage #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(val64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64)
`ifdef IMM_DECODE_STATS_EN
    , .stat_pops(sp64), .stat_illegal(si64)
`endif
  );

  typedef struct packed {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill32;
    logic             ill64;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  int   checks = 0;
  int   failures = 0;
  int   n_pops = 0;
  int   n_ill = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares outputs against the scoreboard head, then tracks handshakes across the next edge.
  task automatic tick();
    logic can_push;
    @(negedge clk);
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      can_push = (sb.size() < DEPTH);
      check("in_ready32", 64'(rdy32), 64'(can_push));
      check("in_ready64", 64'(rdy64), 64'(can_push));
      check("out_valid32", 64'(val32), 64'(sb.size() != 0));
      check("out_valid64", 64'(val64), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        check("imm32", 64'(imm32), 64'(sb[0].imm[31:0]));
        check("imm64", imm64, sb[0].imm);
        check("tag32", 64'(tag32), 64'(sb[0].tag));
        check("tag64", 64'(tag64), 64'(sb[0].tag));
        check("ill32", 64'(ill32), 64'(sb[0].ill32));
        check("ill64", 64'(ill64), 64'(sb[0].ill64));
        if (out_ready) begin
          if (sb[0].ill32) n_ill++;
          void'(sb.pop_front());
          n_pops++;
        end
      end else begin
        check("idle_zero32", {31'd0, imm32, tag32 != '0 || ill32}, 64'd0);
        check("idle_zero64", imm64 | 64'({tag64, ill64}), 64'd0);
      end
      if (in_valid && can_push) sb.push_back(pend);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] src, input logic [24:0] instr, input logic [TAG_W-1:0] tag,
                     input logic [63:0] imm, input logic i32, input logic i64);
    in_valid   = 1'b1;
    in_imm_src = src;
    in_instr   = instr;
    in_tag     = tag;
    pend       = '{imm: imm, tag: tag, ill32: i32, ill64: i64};
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 25'd0; in_imm_src = 3'd0; in_tag = '0; pend = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Decode vectors, one push per cycle with the consumer always ready.
    put(3'b000, 25'h1000000, 4'd1, 64'hFFFF_FFFF_FFFF_F800, 1'b0, 1'b0); tick();
    put(3'b010, 25'h0666666, 4'd2, 64'h0000_0000_3333_3000, 1'b0, 1'b0); tick();
    put(3'b101, 25'h1FC001D, 4'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0); tick();
    put(3'b111, 25'h1FFFFFF, 4'd4, 64'h0,                   1'b1, 1'b1); tick();
    put(3'b100, 25'h0040000, 4'd5, 64'h20,                  1'b1, 1'b0); tick();
    put(3'b100, 25'h000A000, 4'd6, 64'h5,                   1'b0, 1'b0); tick();
    put(3'b011, 25'h0001500, 4'd7, 64'h15,                  1'b0, 1'b0); tick();
    put(3'b001, 25'h1000001, 4'd8, 64'hFFFF_FFFF_FFFF_F801, 1'b0, 1'b0); tick();
    put(3'b110, 25'h1000000, 4'd9, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 1'b0); tick();
    put(3'b010, 25'h1FFFFFF, 4'hA, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 1'b0); tick();
    in_valid = 1'b0; tick(); tick();

    // Backpressure: fill, hold a third request, then drain in order across pointer wrap.
    out_ready = 1'b0;
    put(3'b000, 25'h0002000, 4'd1, 64'h1, 1'b0, 1'b0); tick();
    put(3'b000, 25'h0004000, 4'd2, 64'h2, 1'b0, 1'b0); tick();
    put(3'b000, 25'h0006000, 4'd3, 64'h3, 1'b0, 1'b0); tick(); tick();
    out_ready = 1'b1; tick(); tick();
    in_valid = 1'b0; tick(); tick();
    check("drained", 64'(sb.size()), 64'd0);

    // Flush with a concurrent push: everything, including the new request, is dropped.
    out_ready = 1'b0;
    put(3'b000, 25'h0002000, 4'd1, 64'h1, 1'b0, 1'b0); tick();
    put(3'b000, 25'h0004000, 4'd2, 64'h2, 1'b0, 1'b0); tick();
    put(3'b000, 25'h0012000, 4'd9, 64'h9, 1'b0, 1'b0); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick(); tick();
`ifdef IMM_DECODE_STATS_EN
    check("stat_pops32", 64'(sp32), 64'(n_pops));
    check("stat_ill32", 64'(si32), 64'(n_ill));
    check("stat_pops64", 64'(sp64), 64'(n_pops));
`endif

    // Reset with two entries buffered.
    out_ready = 1'b0;
    put(3'b001, 25'h1000001, 4'd5, 64'hFFFF_FFFF_FFFF_F801, 1'b0, 1'b0); tick();
    put(3'b111, 25'h0000000, 4'd6, 64'h0,                   1'b1, 1'b1); tick();
    in_valid = 1'b0; rst_n = 1'b0; tick();
    rst_n = 1'b1; out_ready = 1'b1; tick(); tick();
`ifdef IMM_DECODE_STATS_EN
    check("stat_pops_rst", 64'(sp32), 64'd0);
    check("stat_ill_rst", 64'(si32), 64'd0);
`endif
    put(3'b000, 25'h1000000, 4'hF, 64'hFFFF_FFFF_FFFF_F800, 1'b0, 1'b0); tick();
    in_valid = 1'b0; tick(); tick();
    check("final_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
